// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU issue sequencer: op-select codes, FSM states
// and the op-to-latency mapping used by the latency LUT and counter sizing.
package fpu_seq_pkg;

    localparam int unsigned FOP_ADD  = 0;
    localparam int unsigned FOP_SUB  = 1;
    localparam int unsigned FOP_MUL  = 2;
    localparam int unsigned FOP_DIV  = 3;
    localparam int unsigned FOP_SQRT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned fop_latency(
        input int unsigned sel,
        input int unsigned lat_addsub,
        input int unsigned lat_mul,
        input int unsigned lat_div,
        input int unsigned lat_misc
    );
        case (sel)
            FOP_ADD, FOP_SUB:  return lat_addsub;
            FOP_MUL:           return lat_mul;
            FOP_DIV, FOP_SQRT: return lat_div;
            default:           return lat_misc;
        endcase
    endfunction

    function automatic int unsigned lat_max(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fpu_issue_seq_if.sv
// EX / FPU / write-back signal bundle for the FPU issue sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface fpu_issue_seq_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned TAG_W  = 5
);
    logic              ex_valid;
    logic [SEL_W-1:0]  selFPU;
    logic [TAG_W-1:0]  ex_tag;
    logic              flush;
    logic [DATA_W-1:0] fpu_result;

    logic              fpu_start;
    logic [SEL_W-1:0]  fpu_sel;
    logic              stall;
    logic              busy;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic [31:0]       perf_ops;
    logic [31:0]       perf_stall;

    modport master (
        output ex_valid, selFPU, ex_tag, flush, fpu_result,
        input  fpu_start, fpu_sel, stall, busy, wb_valid, wb_data, wb_tag,
               perf_ops, perf_stall
    );

    modport slave (
        input  ex_valid, selFPU, ex_tag, flush, fpu_result,
        output fpu_start, fpu_sel, stall, busy, wb_valid, wb_data, wb_tag,
               perf_ops, perf_stall
    );
endinterface

// File: rtl/fpu_lat_lut.sv
// Combinational op-select to latency lookup; emits L-1, the value the
// sequencer loads into its countdown on issue.
module fpu_lat_lut
    import fpu_seq_pkg::*;
#(
    parameter int unsigned SEL_W      = 5,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned LAT_ADDSUB = 2,
    parameter int unsigned LAT_MUL    = 3,
    parameter int unsigned LAT_DIV    = 16,
    parameter int unsigned LAT_MISC   = 1
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [CNT_W-1:0] cnt_init_o
);
    int unsigned lat;

    always_comb begin
        lat        = fop_latency(32'(sel_i), LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_MISC);
        cnt_init_o = CNT_W'(lat - 1);
    end
endmodule

// File: rtl/fpu_issue_seq.sv
// FPU issue sequencer: launches one FP op, stalls for its fixed latency, then
// emits a single write-back beat. Optional perf counters under FPU_PERF_CNT_EN.
module fpu_issue_seq
    import fpu_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_W      = 5,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned LAT_ADDSUB = 2,
    parameter int unsigned LAT_MUL    = 3,
    parameter int unsigned LAT_DIV    = 16,
    parameter int unsigned LAT_MISC   = 1
) (
    input logic           clk,
    input logic           rst,
    fpu_issue_seq_if.slave bus
);
    localparam int unsigned LAT_MAX = lat_max(LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_MISC);
    localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_init;
    logic [SEL_W-1:0]  sel_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              issue;

    fpu_lat_lut #(
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .LAT_ADDSUB (LAT_ADDSUB),
        .LAT_MUL    (LAT_MUL),
        .LAT_DIV    (LAT_DIV),
        .LAT_MISC   (LAT_MISC)
    ) u_lat_lut (
        .sel_i      (bus.selFPU),
        .cnt_init_o (cnt_init)
    );

    assign issue = (state_q == ST_IDLE) && bus.ex_valid && !bus.flush;

    // NOTE: state is updated with non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (bus.flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ex_valid) begin
                        sel_q   <= bus.selFPU;
                        tag_q   <= bus.ex_tag;
                        cnt_q   <= cnt_init;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        data_q  <= bus.fpu_result;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // ex_valid here belongs to the completing op, so no relaunch.
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.fpu_start = issue;
    assign bus.stall     = issue || (state_q == ST_RUN);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.wb_valid  = (state_q == ST_DONE) && !bus.flush;
    assign bus.fpu_sel   = sel_q;
    assign bus.wb_tag    = tag_q;
    assign bus.wb_data   = data_q;

`ifdef FPU_PERF_CNT_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_q + 32'(bus.wb_valid);
            perf_stall_q <= perf_stall_q + 32'(bus.stall);
        end
    end

    assign bus.perf_ops   = perf_ops_q;
    assign bus.perf_stall = perf_stall_q;
`else
    assign bus.perf_ops   = '0;
    assign bus.perf_stall = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Self-checking bench for fpu_issue_seq: per-cycle comparison against a
// cycle-age reference model, plus directed scenarios with literal expectations.
module tb_fpu_issue_seq;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned TAG_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_issue_seq_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .TAG_W(TAG_W)) bus ();

    fpu_issue_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit fixed_res = 1'b0;

    // Reference model: an op is "active" from the cycle after issue; age counts cycles since issue.
    bit          m_active;
    int          m_age;
    int          m_lat;
    logic [4:0]  m_sel;
    logic [4:0]  m_tag;
    logic [31:0] m_data;
    logic [31:0] m_ops;
    logic [31:0] m_stalls;
    logic        e_stall_c;
    logic        e_wb_c;

    // Observations of the DUT used by the directed scenarios.
    int          n_start;
    int          n_stall;
    int          wb_cyc_q[$];
    int          wb_tag_q[$];
    logic [31:0] last_wb_data;

    function automatic int ref_lat(input logic [4:0] sel);
        case (sel)
            5'd0, 5'd1: return 2;
            5'd2:       return 3;
            5'd3, 5'd4: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_lat    = 0;
        m_sel    = '0;
        m_tag    = '0;
        m_data   = '0;
        m_ops    = '0;
        m_stalls = '0;
    endtask

    task automatic clear_obs();
        n_start = 0;
        n_stall = 0;
        wb_cyc_q.delete();
        wb_tag_q.delete();
        last_wb_data = '0;
    endtask

    task automatic compare();
        logic e_start;
        logic e_busy;
        e_start   = !m_active && bus.ex_valid && !bus.flush;
        e_stall_c = e_start || (m_active && m_age <= m_lat);
        e_busy    = m_active;
        e_wb_c    = m_active && (m_age == m_lat + 1) && !bus.flush;
        check("fpu_start", 64'(bus.fpu_start), 64'(e_start));
        check("stall",     64'(bus.stall),     64'(e_stall_c));
        check("busy",      64'(bus.busy),      64'(e_busy));
        check("wb_valid",  64'(bus.wb_valid),  64'(e_wb_c));
        check("fpu_sel",   64'(bus.fpu_sel),   64'(m_sel));
        check("wb_tag",    64'(bus.wb_tag),    64'(m_tag));
        check("wb_data",   64'(bus.wb_data),   64'(m_data));
`ifdef FPU_PERF_CNT_EN
        check("perf_ops",   64'(bus.perf_ops),   64'(m_ops));
        check("perf_stall", 64'(bus.perf_stall), 64'(m_stalls));
`else
        check("perf_ops",   64'(bus.perf_ops),   64'd0);
        check("perf_stall", 64'(bus.perf_stall), 64'd0);
`endif
    endtask

    task automatic advance();
        m_ops    = m_ops + 32'(e_wb_c);
        m_stalls = m_stalls + 32'(e_stall_c);
        if (bus.flush) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (bus.ex_valid) begin
                m_active = 1'b1;
                m_age    = 1;
                m_lat    = ref_lat(bus.selFPU);
                m_sel    = bus.selFPU;
                m_tag    = bus.ex_tag;
            end
        end else begin
            if (m_age == m_lat) m_data = bus.fpu_result;
            if (m_age == m_lat + 1) m_active = 1'b0;
            else m_age++;
        end
    endtask

    task automatic step(input logic ev, input logic [4:0] sel, input logic [4:0] tag, input logic fl);
        @(negedge clk);
        bus.ex_valid   = ev;
        bus.selFPU     = sel;
        bus.ex_tag     = tag;
        bus.flush      = fl;
        bus.fpu_result = fixed_res ? (32'hC0DE_0000 + 32'(cyc)) : $urandom;
        #1;
        compare();
        if (bus.fpu_start) n_start++;
        if (bus.stall) n_stall++;
        if (bus.wb_valid) begin
            wb_cyc_q.push_back(cyc);
            wb_tag_q.push_back(int'(bus.wb_tag));
            last_wb_data = bus.wb_data;
        end
        advance();
        cyc++;
    endtask

    // Asserts rst away from any clock edge and checks outputs drop before the next edge.
    task automatic do_reset();
        #2;
        rst            = 1'b1;
        bus.ex_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.selFPU     = '0;
        bus.ex_tag     = '0;
        bus.fpu_result = '0;
        m_reset();
        #1;
        check("rst_busy",     64'(bus.busy),      64'd0);
        check("rst_stall",    64'(bus.stall),     64'd0);
        check("rst_wb_valid", 64'(bus.wb_valid),  64'd0);
        compare();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        m_reset();
        clear_obs();

        // 1) single add, known result values
        do_reset();
        clear_obs();
        fixed_res = 1'b1;
        t0 = cyc;
        repeat (4) step(1'b1, 5'd0, 5'd3, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        check("add_starts", 64'(n_start), 64'd1);
        check("add_stalls", 64'(n_stall), 64'd3);
        check("add_wb_cnt", 64'(wb_cyc_q.size()), 64'd1);
        check("add_wb_cyc", 64'(wb_cyc_q[0]), 64'(t0 + 3));
        check("add_wb_data", 64'(last_wb_data), 64'(32'hC0DE_0000 + 32'(t0 + 2)));
        check("add_wb_tag", 64'(wb_tag_q[0]), 64'd3);
        fixed_res = 1'b0;

        // 2) div: 17 stall cycles, single launch
        clear_obs();
        t0 = cyc;
        repeat (18) step(1'b1, 5'd3, 5'd4, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        check("div_starts", 64'(n_start), 64'd1);
        check("div_stalls", 64'(n_stall), 64'd17);
        check("div_wb_cyc", 64'(wb_cyc_q[0]), 64'(t0 + 17));

        // 3) mul then add back to back
        clear_obs();
        t0 = cyc;
        repeat (5) step(1'b1, 5'd2, 5'd7, 1'b0);
        repeat (4) step(1'b1, 5'd0, 5'd9, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        check("b2b_starts", 64'(n_start), 64'd2);
        check("b2b_wb_cnt", 64'(wb_cyc_q.size()), 64'd2);
        check("b2b_wb0_cyc", 64'(wb_cyc_q[0]), 64'(t0 + 4));
        check("b2b_wb1_cyc", 64'(wb_cyc_q[1]), 64'(t0 + 8));
        check("b2b_wb0_tag", 64'(wb_tag_q[0]), 64'd7);
        check("b2b_wb1_tag", 64'(wb_tag_q[1]), 64'd9);

        // 4) flush mid-div, then flush alongside ex_valid in IDLE
        clear_obs();
        repeat (5) step(1'b1, 5'd3, 5'd1, 1'b0);
        step(1'b1, 5'd3, 5'd1, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0);
        check("flush_stall_drop", 64'(bus.stall), 64'd0);
        check("flush_busy_drop",  64'(bus.busy),  64'd0);
        repeat (20) step(1'b0, 5'd0, 5'd0, 1'b0);
        check("flush_no_wb", 64'(wb_cyc_q.size()), 64'd0);
        clear_obs();
        step(1'b1, 5'd3, 5'd1, 1'b1);
        check("flush_idle_no_start", 64'(n_start), 64'd0);

        // 5) async reset mid-div
        clear_obs();
        repeat (6) step(1'b1, 5'd3, 5'd2, 1'b0);
        do_reset();
        clear_obs();
        repeat (20) step(1'b0, 5'd0, 5'd0, 1'b0);
        check("rst_no_wb", 64'(wb_cyc_q.size()), 64'd0);

        // 6) perf counters after add + mul
        do_reset();
        repeat (4) step(1'b1, 5'd0, 5'd5, 1'b0);
        repeat (5) step(1'b1, 5'd2, 5'd6, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0);
`ifdef FPU_PERF_CNT_EN
        check("perf_ops_lit",   64'(bus.perf_ops),   64'd2);
        check("perf_stall_lit", 64'(bus.perf_stall), 64'd7);
`else
        check("perf_ops_lit",   64'(bus.perf_ops),   64'd0);
        check("perf_stall_lit", 64'(bus.perf_stall), 64'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       ev;
            logic       fl;
            logic [4:0] sel;
            ev  = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 99) < 3);
            sel = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            step(ev, sel, 5'($urandom), fl);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
